multicycle_main_control: RTL and testbench

//  Multicycle MIPS main control FSM; the producing end of the ALUop/funct_imm interface decoded by ALUcontrol.

---
 rtl/multicycle_main_control.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Multicycle MIPS main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath selects and ALUop/funct_imm.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP with a sticky illegal_op flag.
module multicycle_main_control #(
    parameter int STATE_W = 4,
    parameter int FIMM_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         instr_op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               branch_ne,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic               zero_ext,
    output logic [1:0]         ALUop,
    output logic [FIMM_W-1:0]  funct_imm,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEM_ADDR = STATE_W'(2),
        S_MEM_RD   = STATE_W'(3),
        S_WB_MEM   = STATE_W'(4),
        S_MEM_WR   = STATE_W'(5),
        S_EXEC_R   = STATE_W'(6),
        S_WB_R     = STATE_W'(7),
        S_BRANCH   = STATE_W'(8),
        S_JUMP     = STATE_W'(9),
        S_EXEC_I   = STATE_W'(10),
        S_WB_I     = STATE_W'(11)
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP   = STATE_W'(12)
`endif
    } state_t;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       bne;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       fetch;
        logic       m2r;
        logic       rdst;
        logic       rwr;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcs;
        logic       zext;
        logic [1:0] aluop;
    } ctl_t;

    // Moore decode of one state; op is the opcode latched for that instruction.
    function automatic ctl_t ctl_of(input state_t s, input logic [5:0] op);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mrd   = 1'b1;
                c.fetch = 1'b1;
                c.srcb  = 2'b01;
            end
            S_DECODE:   c.srcb = 2'b11;
            S_MEM_ADDR: begin
                c.srca = 1'b1;
                c.srcb = 2'b10;
            end
            S_MEM_RD: begin
                c.mrd  = 1'b1;
                c.iord = 1'b1;
            end
            S_WB_MEM: begin
                c.rwr = 1'b1;
                c.m2r = 1'b1;
            end
            S_MEM_WR: begin
                c.mwr  = 1'b1;
                c.iord = 1'b1;
            end
            S_EXEC_R: begin
                c.srca  = 1'b1;
                c.aluop = 2'b10;
            end
            S_WB_R: begin
                c.rwr  = 1'b1;
                c.rdst = 1'b1;
            end
            S_BRANCH: begin
                c.srca  = 1'b1;
                c.aluop = 2'b01;
                c.pcs   = 2'b01;
                c.pcwc  = 1'b1;
                c.bne   = (op == OP_BNE);
            end
            S_JUMP: begin
                c.pcs = 2'b10;
                c.pcw = 1'b1;
            end
            S_EXEC_I: begin
                c.srca  = 1'b1;
                c.srcb  = 2'b10;
                c.aluop = 2'b11;
                c.zext  = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
            end
            S_WB_I: c.rwr = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [FIMM_W-1:0] fimm_of(input logic [5:0] op);
        case (op)
            OP_ANDI: return FIMM_W'(1);
            OP_ORI:  return FIMM_W'(2);
            OP_XORI: return FIMM_W'(3);
            OP_SLTI: return FIMM_W'(4);
            default: return FIMM_W'(0);
        endcase
    endfunction

    state_t              r_state;
    state_t              w_next;
    ctl_t                r_ctl;
    logic [5:0]          r_op;
    logic [5:0]          w_op_next;
    logic [FIMM_W-1:0]   r_fimm;
    logic                r_illegal;
    logic                w_unknown_op;

    assign w_op_next = (r_state == S_DECODE) ? instr_op : r_op;

    always_comb begin
        w_next       = r_state;
        w_unknown_op = 1'b0;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (instr_op)
                    OP_RTYPE:                   w_next = S_EXEC_R;
                    OP_LW, OP_SW:               w_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:             w_next = S_BRANCH;
                    OP_J:                       w_next = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI,
                    OP_XORI, OP_SLTI:           w_next = S_EXEC_I;
                    default: begin
                        w_unknown_op = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                        w_next = S_TRAP;
`else
                        w_next = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM_ADDR: w_next = (r_op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_next = S_WB_MEM;
            S_WB_MEM:   w_next = S_FETCH;
            S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
            S_EXEC_R:   w_next = S_WB_R;
            S_WB_R:     w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JUMP:     w_next = S_FETCH;
            S_EXEC_I:   w_next = S_WB_I;
            S_WB_I:     w_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     w_next = S_TRAP;
`endif
            default:    w_next = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_op      <= '0;
            r_fimm    <= '0;
            r_ctl     <= ctl_of(S_FETCH, 6'd0);
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            r_op    <= w_op_next;
            r_ctl   <= ctl_of(w_next, w_op_next);
            if (r_state == S_DECODE) r_fimm <= fimm_of(instr_op);
`ifdef ILLEGAL_TRAP_EN
            if (w_unknown_op) r_illegal <= 1'b1;
`endif
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = r_illegal;
`else
    logic w_unused;
    assign w_unused   = r_illegal ^ w_unknown_op;
    assign illegal_op = 1'b0;
`endif

    // r_ctl resets to the FETCH pattern, so rst_n masks it to keep outputs quiet during reset.
    assign PCWrite     = rst_n & (r_ctl.pcw | (r_ctl.fetch & mem_ready));
    assign IRWrite     = rst_n & r_ctl.fetch & mem_ready;
    assign PCWriteCond = rst_n & r_ctl.pcwc;
    assign branch_ne   = rst_n & r_ctl.bne;
    assign IorD        = rst_n & r_ctl.iord;
    assign MemRead     = rst_n & r_ctl.mrd;
    assign MemWrite    = rst_n & r_ctl.mwr;
    assign MemtoReg    = rst_n & r_ctl.m2r;
    assign RegDst      = rst_n & r_ctl.rdst;
    assign RegWrite    = rst_n & r_ctl.rwr;
    assign ALUSrcA     = rst_n & r_ctl.srca;
    assign ALUSrcB     = r_ctl.srcb & {2{rst_n}};
    assign PCSource    = r_ctl.pcs & {2{rst_n}};
    assign zero_ext    = rst_n & r_ctl.zext;
    assign ALUop       = r_ctl.aluop & {2{rst_n}};
    assign funct_imm   = r_fimm;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: per-cycle expected state/controls queued by the driver, checked by a monitor.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] instr_op = 6'd0;
    logic       mem_ready = 1'b0;
    logic PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite, IRWrite;
    logic MemtoReg, RegDst, RegWrite, ALUSrcA, zero_ext, illegal_op;
    logic [1:0] ALUSrcB, PCSource, ALUop;
    logic [2:0] funct_imm;
    logic [3:0] dbg_state;

    multicycle_main_control #(.STATE_W(4), .FIMM_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .instr_op(instr_op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .branch_ne(branch_ne),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .zero_ext(zero_ext), .ALUop(ALUop), .funct_imm(funct_imm),
        .illegal_op(illegal_op), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    localparam logic [21:0] PCW  = 22'(1) << 21;
    localparam logic [21:0] PCWC = 22'(1) << 20;
    localparam logic [21:0] BNE  = 22'(1) << 19;
    localparam logic [21:0] IORD = 22'(1) << 18;
    localparam logic [21:0] MRD  = 22'(1) << 17;
    localparam logic [21:0] MWR  = 22'(1) << 16;
    localparam logic [21:0] IRW  = 22'(1) << 15;
    localparam logic [21:0] M2R  = 22'(1) << 14;
    localparam logic [21:0] RDST = 22'(1) << 13;
    localparam logic [21:0] RWR  = 22'(1) << 12;
    localparam logic [21:0] SRCA = 22'(1) << 11;
    localparam logic [21:0] B_4  = 22'(1) << 9;
    localparam logic [21:0] B_IM = 22'(2) << 9;
    localparam logic [21:0] B_SH = 22'(3) << 9;
    localparam logic [21:0] PC_O = 22'(1) << 7;
    localparam logic [21:0] PC_J = 22'(2) << 7;
    localparam logic [21:0] ZEXT = 22'(1) << 6;
    localparam logic [21:0] A_SB = 22'(1) << 4;
    localparam logic [21:0] A_R  = 22'(2) << 4;
    localparam logic [21:0] A_I  = 22'(3) << 4;
    localparam logic [21:0] ILL  = 22'(1);

    localparam logic [21:0] FETCH_GO   = MRD | B_4 | IRW | PCW;
    localparam logic [21:0] FETCH_WAIT = MRD | B_4;

    function automatic logic [21:0] fi(input logic [2:0] v);
        return {18'd0, v, 1'b0};
    endfunction

    logic [21:0] got;
    assign got = {PCWrite, PCWriteCond, branch_ne, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, zero_ext,
                  ALUop, funct_imm, illegal_op};

    logic [25:0] exp_q[$];
    int n_chk  = 0;
    int n_fail = 0;
    int n_pop  = 0;

    // Monitor: one expected entry per clock, compared mid-cycle.
    initial begin
        logic [25:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pop++;
                n_chk++;
                if (dbg_state !== e[25:22]) begin
                    n_fail++;
                    $display("FAIL state #%0d: got %0d expected %0d", n_pop, dbg_state, e[25:22]);
                end
                n_chk++;
                if (got !== e[21:0]) begin
                    n_fail++;
                    $display("FAIL ctl #%0d (state %0d): got %h expected %h", n_pop, e[25:22], got, e[21:0]);
                end
            end
        end
    end

    task automatic step(input logic [5:0] op, input logic mr, input logic [3:0] st, input logic [21:0] ctl);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        instr_op  = op;
        mem_ready = mr;
        exp_q.push_back({st, ctl});
    endtask

    task automatic rst_step();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        exp_q.push_back({4'd0, 22'd0});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_step();
        rst_step();

        // add: 0,1,6,7
        step(6'b000000, 1'b1, 4'd0, FETCH_GO);
        step(6'b000000, 1'b1, 4'd1, B_SH);
        step(6'b000000, 1'b1, 4'd6, SRCA | A_R);
        step(6'b000000, 1'b1, 4'd7, RWR | RDST);

        // lw with three MEM_RD wait cycles
        step(6'b100011, 1'b1, 4'd0, FETCH_GO);
        step(6'b100011, 1'b1, 4'd1, B_SH);
        step(6'b100011, 1'b1, 4'd2, SRCA | B_IM);
        step(6'b100011, 1'b0, 4'd3, MRD | IORD);
        step(6'b100011, 1'b0, 4'd3, MRD | IORD);
        step(6'b100011, 1'b0, 4'd3, MRD | IORD);
        step(6'b100011, 1'b1, 4'd3, MRD | IORD);
        step(6'b100011, 1'b1, 4'd4, RWR | M2R);

        // ori then slti
        step(6'b001101, 1'b1, 4'd0, FETCH_GO);
        step(6'b001101, 1'b1, 4'd1, B_SH);
        step(6'b001101, 1'b1, 4'd10, SRCA | B_IM | A_I | ZEXT | fi(3'd2));
        step(6'b001101, 1'b1, 4'd11, RWR | fi(3'd2));
        step(6'b001010, 1'b1, 4'd0, FETCH_GO | fi(3'd2));
        step(6'b001010, 1'b1, 4'd1, B_SH | fi(3'd2));
        step(6'b001010, 1'b1, 4'd10, SRCA | B_IM | A_I | fi(3'd4));
        step(6'b001010, 1'b1, 4'd11, RWR | fi(3'd4));

        // bne, beq, j
        step(6'b000101, 1'b1, 4'd0, FETCH_GO | fi(3'd4));
        step(6'b000101, 1'b1, 4'd1, B_SH | fi(3'd4));
        step(6'b000101, 1'b1, 4'd8, SRCA | A_SB | PC_O | PCWC | BNE);
        step(6'b000100, 1'b1, 4'd0, FETCH_GO);
        step(6'b000100, 1'b1, 4'd1, B_SH);
        step(6'b000100, 1'b1, 4'd8, SRCA | A_SB | PC_O | PCWC);
        step(6'b000010, 1'b1, 4'd0, FETCH_GO);
        step(6'b000010, 1'b1, 4'd1, B_SH);
        step(6'b000010, 1'b1, 4'd9, PC_J | PCW);

        // sw with a fetch stall and one write wait cycle
        step(6'b101011, 1'b0, 4'd0, FETCH_WAIT);
        step(6'b101011, 1'b1, 4'd0, FETCH_GO);
        step(6'b101011, 1'b1, 4'd1, B_SH);
        step(6'b101011, 1'b1, 4'd2, SRCA | B_IM);
        step(6'b101011, 1'b0, 4'd5, MWR | IORD);
        step(6'b101011, 1'b1, 4'd5, MWR | IORD);

        // sw aborted by asynchronous reset while MEM_WR is stalled
        step(6'b101011, 1'b1, 4'd0, FETCH_GO);
        step(6'b101011, 1'b1, 4'd1, B_SH);
        step(6'b101011, 1'b1, 4'd2, SRCA | B_IM);
        step(6'b101011, 1'b0, 4'd5, MWR | IORD);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.push_back({4'd0, 22'd0});
        rst_step();
        step(6'b000000, 1'b1, 4'd0, FETCH_GO);
        step(6'b000000, 1'b1, 4'd1, B_SH);
        step(6'b000000, 1'b1, 4'd6, SRCA | A_R);
        step(6'b000000, 1'b1, 4'd7, RWR | RDST);

        // unknown opcode 111111
        step(6'b111111, 1'b1, 4'd0, FETCH_GO);
        step(6'b111111, 1'b1, 4'd1, B_SH);
`ifdef ILLEGAL_TRAP_EN
        step(6'b000000, 1'b1, 4'd12, ILL);
        step(6'b000000, 1'b1, 4'd12, ILL);
        step(6'b000000, 1'b0, 4'd12, ILL);
        rst_step();
        step(6'b000000, 1'b1, 4'd0, FETCH_GO);
        step(6'b000000, 1'b1, 4'd1, B_SH);
`else
        step(6'b000000, 1'b1, 4'd0, FETCH_GO);
        step(6'b000000, 1'b1, 4'd1, B_SH);
        step(6'b000000, 1'b1, 4'd6, SRCA | A_R);
        step(6'b000000, 1'b1, 4'd7, RWR | RDST);
`endif

        repeat (3) @(posedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
